// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing a single-port synchronous-read data RAM between
// the CPU (requester 0) and the debug/DMA port (requester 1).
module data_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy,
    output logic                  gnt_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    start;
    logic                    win_id;
    logic                    win_we;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_wdata;
    logic                    lat_we;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and winner selection; on a tie the last-granted requester yields.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        win_id  = gnt_id;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    start   = 1'b1;
                    state_d = ISSUE;
                    win_id  = (m0_req && m1_req) ? ~gnt_id : m1_req;
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        win_we    = m0_we;
        win_addr  = m0_addr;
        win_wdata = m0_wdata;
        if (win_id) begin
            win_we    = m1_we;
            win_addr  = m1_addr;
            win_wdata = m1_wdata;
        end
    end

    // Registered outputs are loaded from the transition being taken, so each
    // strobe is high for exactly the state it belongs to.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            busy      <= 1'b0;
            gnt_id    <= 1'b1;
            lat_we    <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            busy   <= (state_d != IDLE);
            ram_en <= start;
            ram_we <= start & win_we;
            m0_ack <= (state_q == RESP) && !gnt_id;
            m1_ack <= (state_q == RESP) && gnt_id;
            if (start) begin
                gnt_id    <= win_id;
                lat_we    <= win_we;
                ram_addr  <= win_addr;
                ram_wdata <= win_wdata;
            end
            if ((state_q == RESP) && !lat_we) begin
                if (gnt_id) begin
                    m1_rdata <= ram_rdata;
                end else begin
                    m0_rdata <= ram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural synchronous-read RAM.
module tb_data_mem_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          arst = 1'b0;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          busy, gnt_id;

    logic [DW-1:0] mem [256];
    int            n_vec = 0;
    int            n_err = 0;
    int            ack0_cnt = 0, ack1_cnt = 0, en_cnt = 0, we_cnt = 0;
    logic [AW-1:0] last_waddr = '0;
    logic [DW-1:0] last_wdata = '0;

    data_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .arst(arst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy), .gnt_id(gnt_id)
    );

    always #5 clk = ~clk;

    // Read-first synchronous RAM model
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    always @(negedge clk) begin
        if (m0_ack) ack0_cnt++;
        if (m1_ack) ack1_cnt++;
        if (ram_en) en_cnt++;
        if (ram_en && ram_we) begin
            we_cnt++;
            last_waddr = ram_addr;
            last_wdata = ram_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ram_en"}, 32'(ram_en), 0);
        chk({tag, "_ram_we"}, 32'(ram_we), 0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
        chk({tag, "_ram_wdata"}, 32'(ram_wdata), 0);
        chk({tag, "_m0_ack"}, 32'(m0_ack), 0);
        chk({tag, "_m1_ack"}, 32'(m1_ack), 0);
        chk({tag, "_m0_rdata"}, 32'(m0_rdata), 0);
        chk({tag, "_m1_rdata"}, 32'(m1_rdata), 0);
        chk({tag, "_gnt_id"}, 32'(gnt_id), 1);
    endtask

    task automatic do_reset();
        arst = 1'b0;
        tick();
        tick();
        arst = 1'b1;
        tick();
    endtask

    // Single access by one requester; returns its rdata at ack and the ack latency.
    task automatic access(input bit m, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input string tag,
                          output logic [DW-1:0] rd, output int lat);
        bit got = 1'b0;
        lat = 0;
        if (m) begin
            m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
        end
        while (!got && lat < 16) begin
            tick();
            lat++;
            got = m ? m1_ack : m0_ack;
        end
        chk({tag, "_ack_seen"}, 32'(got), 1);
        rd = m ? m1_rdata : m0_rdata;
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
    endtask

    initial begin
        logic [DW-1:0] rd;
        int            lat;
        int            a0, a1, e0, w0;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 8'hA5;
        mem[8'h20] = 8'h5A;
        mem[8'h01] = 8'h11;
        mem[8'h02] = 8'h22;

        tick();
        chk_reset_vals("rst");
        arst = 1'b1;
        tick();

        // m0 read of 0x10, cycle by cycle
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h10;
        tick();
        chk("rd0_ram_en", 32'(ram_en), 1);
        chk("rd0_ram_we", 32'(ram_we), 0);
        chk("rd0_ram_addr", 32'(ram_addr), 32'h10);
        chk("rd0_busy", 32'(busy), 1);
        chk("rd0_gnt", 32'(gnt_id), 0);
        tick();
        chk("rd0_ram_en_off", 32'(ram_en), 0);
        chk("rd0_ack_early", 32'(m0_ack), 0);
        tick();
        chk("rd0_ack", 32'(m0_ack), 1);
        chk("rd0_rdata", 32'(m0_rdata), 32'hA5);
        chk("rd0_m1_ack", 32'(m1_ack), 0);
        m0_req = 1'b0;
        tick();
        chk("rd0_ack_one_cycle", 32'(m0_ack), 0);
        chk("rd0_busy_off", 32'(busy), 0);

        // m1 read, then write, then read back
        access(1'b1, 1'b0, 8'h20, 8'h00, "m1rd", rd, lat);
        chk("m1rd_lat", 32'(lat), 3);
        chk("m1rd_data", 32'(rd), 32'h5A);
        w0 = we_cnt;
        access(1'b1, 1'b1, 8'h80, 8'h3C, "m1wr", rd, lat);
        chk("m1wr_lat", 32'(lat), 3);
        chk("m1wr_we_pulses", 32'(we_cnt - w0), 1);
        chk("m1wr_addr", 32'(last_waddr), 32'h80);
        chk("m1wr_data", 32'(last_wdata), 32'h3C);
        chk("m1wr_rdata_kept", 32'(rd), 32'h5A);
        access(1'b1, 1'b0, 8'h80, 8'h00, "m1rb", rd, lat);
        chk("m1rb_data", 32'(rd), 32'h3C);

        // Simultaneous request directly after reset: m0 first
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h01;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h02;
        tick();
        chk("tie_gnt0", 32'(gnt_id), 0);
        chk("tie_addr0", 32'(ram_addr), 32'h01);
        tick();
        tick();
        chk("tie_m0_ack", 32'(m0_ack), 1);
        chk("tie_m1_ack_idle", 32'(m1_ack), 0);
        chk("tie_m0_rdata", 32'(m0_rdata), 32'h11);
        m0_req = 1'b0;
        tick();
        chk("tie_busy_gap", 32'(busy), 0);
        tick();
        chk("tie_gnt1", 32'(gnt_id), 1);
        chk("tie_addr1", 32'(ram_addr), 32'h02);
        tick();
        tick();
        chk("tie_m1_ack", 32'(m1_ack), 1);
        chk("tie_m1_rdata", 32'(m1_rdata), 32'h22);
        m1_req = 1'b0;
        tick();
        tick();

        // Both continuously requesting: alternating acks 4 cycles apart
        begin
            int k = 0;
            int cyc = 0;
            m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h01;
            m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h02;
            while (k < 8 && cyc < 60) begin
                tick();
                cyc++;
                if (m0_ack || m1_ack) begin
                    chk("rr_single_ack", 32'(m0_ack && m1_ack), 0);
                    chk("rr_id", 32'(m1_ack), 32'(k % 2));
                    chk("rr_cycle", 32'(cyc), 32'(3 + 4 * k));
                    chk("rr_rdata", 32'(m1_ack ? m1_rdata : m0_rdata), (k % 2) ? 32'h22 : 32'h11);
                    k++;
                end
            end
            chk("rr_count", 32'(k), 8);
            m0_req = 1'b0;
            m1_req = 1'b0;
            tick();
            tick();
        end

        // Reset asserted during ISSUE of an m1 write
        a1 = ack1_cnt;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h40; m1_wdata = 8'h77;
        tick();
        chk("abort_issue_en", 32'(ram_en), 1);
        chk("abort_issue_we", 32'(ram_we), 1);
        arst = 1'b0;
        #1;
        chk_reset_vals("abort");
        m1_req = 1'b0;
        tick();
        tick();
        arst = 1'b1;
        tick();
        tick();
        chk("abort_no_ack", 32'(ack1_cnt - a1), 0);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h01;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h02;
        tick();
        chk("post_abort_gnt", 32'(gnt_id), 0);
        tick();
        tick();
        chk("post_abort_m0_ack", 32'(m0_ack), 1);
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) tick();

        // m0 drops req during RESP: access still completes once
        a0 = ack0_cnt;
        e0 = en_cnt;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h10;
        tick();
        tick();
        m0_req = 1'b0;
        tick();
        chk("drop_ack", 32'(m0_ack), 1);
        chk("drop_rdata", 32'(m0_rdata), 32'hA5);
        for (int i = 0; i < 6; i++) tick();
        chk("drop_ack_count", 32'(ack0_cnt - a0), 1);
        chk("drop_en_count", 32'(en_cnt - e0), 1);
        chk("drop_idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter that shares the single-port, synchronous-read data RAM between the CPU instruction-cycle unit (requester 0) and a debug/DMA port (requester 1). It serialises accesses with round-robin priority and drives the RAM address, data and write-enable from registers. It returns read data and a one-cycle acknowledge to the winning requester. It sits between the core's memory interface and the data RAM macro.

## Interface
- ADDR_WIDTH, 8, RAM address width
- DATA_WIDTH, 8, RAM data width

- clk  in  1  system clock, rising edge
- arst  in  1  reset; one clock domain, asynchronous, active-low
- m0_req / m1_req  in  1  access request; held high until ack
- m0_we / m1_we  in  1  1 = write, 0 = read; stable while req high
- m0_addr / m1_addr  in  ADDR_WIDTH  access address; stable while req high
- m0_wdata / m1_wdata  in  DATA_WIDTH  write data; stable while req high
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  DATA_WIDTH  read data; valid with ack and held until that requester's next read ack
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after the en/addr cycle
- busy  out  1  high whenever the FSM is not in IDLE
- gnt_id  out  1  requester currently or last granted

## Operation
- FSM states: IDLE, ISSUE, RESP, DONE.
- **IDLE**
  - If any req is high, pick the winner and go to ISSUE.
  - If both are high, the winner is the requester that is not gnt_id (round-robin).
  - Latch the winner's we, addr and wdata into the RAM output registers.
  - Set gnt_id to the winner.
- **ISSUE**
  - ram_en = 1; ram_we = latched we.
  - Always go to RESP.
- **RESP**
  - ram_en = ram_we = 0.
  - On a read, capture ram_rdata into the winner's rdata register.
  - Go to DONE.
- **DONE**
  - Winner's ack = 1; the other ack = 0.
  - All reqs are ignored in this state.
  - Return to IDLE.
- The loser of a simultaneous request keeps req high and is granted in the next IDLE.
- Write access: the winner's rdata is unchanged.
- A requester dropping req before ack is a protocol violation. The in-flight access still completes and ack still pulses.
- ram_addr and ram_wdata hold their last values outside ISSUE. Only ram_en and ram_we qualify an access.

## Timing
- Reset (arst low, asynchronous) forces:
  - state IDLE; busy 0;
  - ram_en, ram_we, ram_addr, ram_wdata = 0;
  - both acks = 0; both rdata = 0;
  - gnt_id = 1, so requester 0 wins the first tie.
- Reset mid-access aborts the access immediately. No ack is produced, and the aborted write may or may not have reached the RAM.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency, with req first sampled high in IDLE at edge E0:
  - ram_en high in cycle E0→E1;
  - ram_rdata valid in cycle E1→E2;
  - ack high and rdata valid in cycle E2→E3.
- The requester samples ack at E3 and may drop req or present a new request. That request is sampled in IDLE at E4.
- Throughput: one access per 4 cycles. With both requesters continuously active, grants strictly alternate.
- busy is high from E0+ until the DONE→IDLE edge.

## Test plan
- Reset, then m0 read of addr 0x10 with RAM[0x10] = 0xA5 → ram_en for one cycle at addr 0x10, m0_ack 3 cycles later, m0_rdata = 0xA5, m1_ack stays 0.
- m1 write of 0x3C to addr 0x80, then m1 read of 0x80 → one ram_we pulse with addr 0x80 / data 0x3C; the read returns 0x3C; m1_rdata is unchanged by the write ack.
- m0 and m1 requesting in the same cycle directly after reset → m0 served first and m1 second; gnt_id goes 0 then 1.
- Both requesters holding req continuously for 8 accesses → acks alternate m0, m1, m0, …, with exactly 4 cycles between consecutive acks.
- arst asserted during ISSUE of an m1 write → all outputs return to reset values asynchronously, no ack is produced, and the next request after release is arbitrated with m0 priority.
- m0 drops req during RESP → m0_ack still pulses once, and no further access is issued for m0.
